// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: WB / JAL link / debug requesters with starvation
// override, plus a sequenced bulk clear of R1..R15. Write outputs are registered.
module rf_write_arbiter #(
    parameter int DSIZE        = 16,
    parameter int RSIZE        = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             WbValid,
    input  logic [RSIZE-1:0] WbAddr,
    input  logic [DSIZE-1:0] WbData,
    output logic             WbReady,
    input  logic             LnkValid,
    input  logic [DSIZE-1:0] LnkData,
    output logic             LnkReady,
    input  logic             DbgValid,
    input  logic [RSIZE-1:0] DbgAddr,
    input  logic [DSIZE-1:0] DbgData,
    output logic             DbgReady,
    input  logic             ClrReq,
    output logic             ClrBusy,
    output logic             Wen,
    output logic [RSIZE-1:0] WAddr,
    output logic [DSIZE-1:0] WData
);

    localparam int AW = $clog2(STARVE_LIMIT + 1);
    localparam logic [RSIZE-1:0] LAST_REG = '1;

    typedef enum logic {ARB, CLEAR} state_t;

    state_t           state_reg;
    logic [RSIZE-1:0] clr_addr_reg;
    logic             wen_reg;
    logic [RSIZE-1:0] waddr_reg;
    logic [DSIZE-1:0] wdata_reg;
    logic             clr_busy_reg;
    logic [AW-1:0]    age_reg [2];
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0]       starved;
    logic             wb_gnt, lnk_gnt, dbg_gnt;

    // Index 0 is the link requester, index 1 the debug requester.
    assign req_valid = {DbgValid, LnkValid};
    assign req_ready = {dbg_gnt, lnk_gnt};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_age
            assign starved[gi] = req_valid[gi] && (age_reg[gi] == AW'(STARVE_LIMIT));

            always_ff @(posedge Clock) begin
                if (!Reset) begin
                    age_reg[gi] <= '0;
                end else if (!req_valid[gi] || req_ready[gi]) begin
                    age_reg[gi] <= '0;
                end else if (age_reg[gi] != AW'(STARVE_LIMIT)) begin
                    age_reg[gi] <= age_reg[gi] + AW'(1);
                end
            end
        end
    endgenerate

    // Starved requesters jump the fixed WB > LNK > DBG order, link first.
    always_comb begin
        wb_gnt  = 1'b0;
        lnk_gnt = 1'b0;
        dbg_gnt = 1'b0;
        if (Reset && state_reg == ARB && !ClrReq) begin
            if (starved[0])      lnk_gnt = 1'b1;
            else if (starved[1]) dbg_gnt = 1'b1;
            else if (WbValid)    wb_gnt  = 1'b1;
            else if (LnkValid)   lnk_gnt = 1'b1;
            else if (DbgValid)   dbg_gnt = 1'b1;
        end
    end

    assign WbReady  = wb_gnt;
    assign LnkReady = lnk_gnt;
    assign DbgReady = dbg_gnt;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_reg    <= ARB;
            clr_addr_reg <= '0;
            wen_reg      <= 1'b0;
            waddr_reg    <= '0;
            wdata_reg    <= '0;
            clr_busy_reg <= 1'b0;
        end else begin
            wen_reg <= 1'b0;
            case (state_reg)
                ARB: begin
                    clr_busy_reg <= ClrReq;
                    if (ClrReq) begin
                        state_reg    <= CLEAR;
                        clr_addr_reg <= RSIZE'(1);
                    end else if (wb_gnt) begin
                        // Writes to R0 are accepted but never reach the file.
                        if (WbAddr != '0) begin
                            wen_reg   <= 1'b1;
                            waddr_reg <= WbAddr;
                            wdata_reg <= WbData;
                        end
                    end else if (lnk_gnt) begin
                        wen_reg   <= 1'b1;
                        waddr_reg <= LAST_REG;
                        wdata_reg <= LnkData;
                    end else if (dbg_gnt) begin
                        if (DbgAddr != '0) begin
                            wen_reg   <= 1'b1;
                            waddr_reg <= DbgAddr;
                            wdata_reg <= DbgData;
                        end
                    end
                end
                CLEAR: begin
                    wen_reg      <= 1'b1;
                    waddr_reg    <= clr_addr_reg;
                    wdata_reg    <= '0;
                    clr_busy_reg <= 1'b1;
                    if (clr_addr_reg == LAST_REG) begin
                        state_reg <= ARB;
                    end else begin
                        clr_addr_reg <= clr_addr_reg + RSIZE'(1);
                    end
                end
                default: state_reg <= ARB;
            endcase
        end
    end

    assign Wen     = wen_reg;
    assign WAddr   = waddr_reg;
    assign WData   = wdata_reg;
    assign ClrBusy = clr_busy_reg;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed testbench for rf_write_arbiter: one task per scenario, inline checks
// against hand-computed expectations.
module tb_rf_write_arbiter;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        WbValid, LnkValid, DbgValid, ClrReq;
    logic [3:0]  WbAddr, DbgAddr;
    logic [15:0] WbData, LnkData, DbgData;
    logic        WbReady, LnkReady, DbgReady, ClrBusy, Wen;
    logic [3:0]  WAddr;
    logic [15:0] WData;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    rf_write_arbiter #(.DSIZE(16), .RSIZE(4), .STARVE_LIMIT(4)) dut (
        .Clock(Clock), .Reset(Reset),
        .WbValid(WbValid), .WbAddr(WbAddr), .WbData(WbData), .WbReady(WbReady),
        .LnkValid(LnkValid), .LnkData(LnkData), .LnkReady(LnkReady),
        .DbgValid(DbgValid), .DbgAddr(DbgAddr), .DbgData(DbgData), .DbgReady(DbgReady),
        .ClrReq(ClrReq), .ClrBusy(ClrBusy),
        .Wen(Wen), .WAddr(WAddr), .WData(WData)
    );

    always #5 Clock = ~Clock;

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b0; WbValid = 1'b1; WbAddr = 4'd2; WbData = 16'h1111;
        LnkValid = 1'b1; LnkData = 16'h2222; DbgValid = 1'b1; DbgAddr = 4'd3;
        DbgData = 16'h3333; ClrReq = 1'b0;
        tick(); tick();
        chk_cnt++; if (Wen !== 1'b0) $display("FAIL reset_wen: got %b want 0", Wen); else pass_cnt++;
        chk_cnt++; if (WAddr !== 4'd0) $display("FAIL reset_waddr: got %h want 0", WAddr); else pass_cnt++;
        chk_cnt++; if (WData !== 16'h0) $display("FAIL reset_wdata: got %h want 0", WData); else pass_cnt++;
        chk_cnt++; if (ClrBusy !== 1'b0) $display("FAIL reset_clrbusy: got %b want 0", ClrBusy); else pass_cnt++;
        chk_cnt++; if ({WbReady, LnkReady, DbgReady} !== 3'b000)
            $display("FAIL reset_ready: got %b want 000", {WbReady, LnkReady, DbgReady}); else pass_cnt++;
        WbValid = 1'b0; LnkValid = 1'b0; DbgValid = 1'b0;
        Reset = 1'b1;
        tick();
        $display("reset released");
    endtask

    task automatic test_wb_only();
        WbValid = 1'b1; WbAddr = 4'd3; WbData = 16'h1234;
        #1;
        chk_cnt++; if ({WbReady, LnkReady, DbgReady} !== 3'b100)
            $display("FAIL wb_ready: got %b want 100", {WbReady, LnkReady, DbgReady}); else pass_cnt++;
        tick();
        WbValid = 1'b0;
        $display("wb write: Wen=%b WAddr=%h WData=%h", Wen, WAddr, WData);
        chk_cnt++; if (Wen !== 1'b1) $display("FAIL wb_wen: got %b want 1", Wen); else pass_cnt++;
        chk_cnt++; if (WAddr !== 4'd3) $display("FAIL wb_waddr: got %h want 3", WAddr); else pass_cnt++;
        chk_cnt++; if (WData !== 16'h1234) $display("FAIL wb_wdata: got %h want 1234", WData); else pass_cnt++;
        tick();
        chk_cnt++; if (Wen !== 1'b0) $display("FAIL wb_wen_idle: got %b want 0", Wen); else pass_cnt++;
        chk_cnt++; if (WAddr !== 4'd3) $display("FAIL wb_waddr_hold: got %h want 3", WAddr); else pass_cnt++;
    endtask

    task automatic test_contention();
        logic [2:0]  exp_rdy;
        logic [3:0]  exp_addr;
        logic [15:0] exp_data;
        WbValid = 1'b1; WbAddr = 4'd2; WbData = 16'h1000;
        LnkValid = 1'b1; LnkData = 16'h0040;
        DbgValid = 1'b1; DbgAddr = 4'd5; DbgData = 16'hBEEF;
        for (int c = 0; c < 7; c++) begin
            // WB wins until LNK starves (cycle 4), then DBG (cycle 5), then WB again.
            if (c == 4)      begin exp_rdy = 3'b010; exp_addr = 4'd15; exp_data = 16'h0040; end
            else if (c == 5) begin exp_rdy = 3'b001; exp_addr = 4'd5;  exp_data = 16'hBEEF; end
            else             begin exp_rdy = 3'b100; exp_addr = 4'd2;  exp_data = WbData;   end
            #1;
            chk_cnt++; if ({WbReady, LnkReady, DbgReady} !== exp_rdy)
                $display("FAIL cont_ready[%0d]: got %b want %b", c, {WbReady, LnkReady, DbgReady}, exp_rdy);
                else pass_cnt++;
            tick();
            $display("contention cycle %0d: Wen=%b WAddr=%h WData=%h", c, Wen, WAddr, WData);
            chk_cnt++; if (Wen !== 1'b1 || WAddr !== exp_addr || WData !== exp_data)
                $display("FAIL cont_write[%0d]: got %b/%h/%h want 1/%h/%h", c, Wen, WAddr, WData, exp_addr, exp_data);
                else pass_cnt++;
            if (c == 4) LnkValid = 1'b0;
            else if (c == 5) DbgValid = 1'b0;
            else WbData = WbData + 16'h1;
        end
        WbValid = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 4; i++) begin
            WbValid = 1'b1; WbAddr = 4'(i + 8); WbData = 16'(16'hA000 + i);
            tick();
            chk_cnt++; if (Wen !== 1'b1 || WAddr !== 4'(i + 8) || WData !== 16'(16'hA000 + i))
                $display("FAIL b2b[%0d]: got %b/%h/%h want 1/%h/%h", i, Wen, WAddr, WData, 4'(i + 8), 16'(16'hA000 + i));
                else pass_cnt++;
        end
        WbValid = 1'b0;
        tick();
    endtask

    task automatic test_r0_write();
        WbValid = 1'b1; WbAddr = 4'd0; WbData = 16'hDEAD;
        #1;
        chk_cnt++; if (WbReady !== 1'b1) $display("FAIL r0_ready: got %b want 1", WbReady); else pass_cnt++;
        tick();
        WbValid = 1'b0;
        chk_cnt++; if (Wen !== 1'b0) $display("FAIL r0_wen: got %b want 0", Wen); else pass_cnt++;
        tick();
    endtask

    task automatic test_clear();
        WbValid = 1'b1; WbAddr = 4'd6; WbData = 16'h5A5A; ClrReq = 1'b1;
        #1;
        chk_cnt++; if (WbReady !== 1'b0) $display("FAIL clr_req_ready: got %b want 0", WbReady); else pass_cnt++;
        tick();
        ClrReq = 1'b0;
        chk_cnt++; if (ClrBusy !== 1'b1 || Wen !== 1'b0)
            $display("FAIL clr_start: got busy=%b wen=%b want busy=1 wen=0", ClrBusy, Wen); else pass_cnt++;
        for (int k = 1; k <= 15; k++) begin
            chk_cnt++; if (WbReady !== 1'b0) $display("FAIL clr_ready[%0d]: got %b want 0", k, WbReady); else pass_cnt++;
            tick();
            $display("clear write: Wen=%b WAddr=%h WData=%h ClrBusy=%b", Wen, WAddr, WData, ClrBusy);
            chk_cnt++; if (Wen !== 1'b1 || WAddr !== 4'(k) || WData !== 16'h0 || ClrBusy !== 1'b1)
                $display("FAIL clr_write[%0d]: got %b/%h/%h busy=%b want 1/%h/0000 busy=1", k, Wen, WAddr, WData, ClrBusy, 4'(k));
                else pass_cnt++;
        end
        chk_cnt++; if (WbReady !== 1'b1) $display("FAIL clr_end_ready: got %b want 1", WbReady); else pass_cnt++;
        tick();
        WbValid = 1'b0;
        chk_cnt++; if (Wen !== 1'b1 || WAddr !== 4'd6 || WData !== 16'h5A5A || ClrBusy !== 1'b0)
            $display("FAIL clr_after_wb: got %b/%h/%h busy=%b want 1/6/5a5a busy=0", Wen, WAddr, WData, ClrBusy);
            else pass_cnt++;
        tick();
    endtask

    task automatic test_reset_mid_clear();
        ClrReq = 1'b1;
        tick();
        ClrReq = 1'b0;
        // Now issuing clear address 1; six more cycles reach address 7.
        for (int k = 0; k < 6; k++) tick();
        chk_cnt++; if (WAddr !== 4'd6) $display("FAIL rmc_pre: got %h want 6", WAddr); else pass_cnt++;
        Reset = 1'b0;
        tick();
        chk_cnt++; if (Wen !== 1'b0 || ClrBusy !== 1'b0 || WAddr !== 4'd0)
            $display("FAIL rmc_reset: got wen=%b busy=%b waddr=%h want 0/0/0", Wen, ClrBusy, WAddr); else pass_cnt++;
        Reset = 1'b1;
        tick();
        chk_cnt++; if (Wen !== 1'b0 || ClrBusy !== 1'b0)
            $display("FAIL rmc_no_resume: got wen=%b busy=%b want 0/0", Wen, ClrBusy); else pass_cnt++;
        WbValid = 1'b1; WbAddr = 4'd9; WbData = 16'h0909;
        #1;
        chk_cnt++; if (WbReady !== 1'b1) $display("FAIL rmc_ready: got %b want 1", WbReady); else pass_cnt++;
        tick();
        WbValid = 1'b0;
        chk_cnt++; if (Wen !== 1'b1 || WAddr !== 4'd9 || WData !== 16'h0909)
            $display("FAIL rmc_write: got %b/%h/%h want 1/9/0909", Wen, WAddr, WData); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_wb_only();
        test_contention();
        test_back_to_back();
        test_r0_write();
        test_clear();
        test_reset_mid_clear();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, %0d/%0d checks passed so far", pass_cnt, chk_cnt);
        $fatal(1, "timeout");
    end

endmodule
